meduram_read_collector: RTL and testbench

Per-read-agent data collector placed directly downstream of the memory-map accounter. For every accepted read it captures the accounter's bank select, delays it to match the RAM read latency, picks the matching write-agent bank's data and queues the word in a small per-agent first-word-fall-through (FWFT) FIFO. The FIFO is drained with a valid/ready handshake. Credit-style flow control keeps the FIFO from ever being overrun by reads already in flight.

---
 rtl/meduram_read_collector.sv | 143 ++++++++++++++
 tb/tb_meduram_read_collector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/meduram_read_collector.sv
// Per-read-agent collector: aligns the accounter's bank select to the RAM latency, picks the bank word, queues it in an FWFT FIFO.
// Latency: rden in cycle T -> rdvalid at T+RAM_LATENCY+1 at the earliest; one word per cycle sustained.
// Backpressure: rdready stalls the FIFO head; rdaccept withholds credits so in-flight reads always fit.
// Optional sticky protocol-error detection is built when MEDURAM_RD_OVERFLOW_CHECK_EN is defined.
module meduram_read_collector #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int NB_WRAGENT      = 2,
    parameter int NB_RDAGENT      = 2,
    parameter int WRITE_COLLISION = 1,
    parameter int SELECT_WIDTH    = (NB_WRAGENT == 1 ? 1 : $clog2(NB_WRAGENT)) + WRITE_COLLISION,
    parameter int RAM_LATENCY     = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic [NB_RDAGENT-1:0]                      rden,
    input  logic [NB_RDAGENT*SELECT_WIDTH-1:0]         bank_select,
    input  logic [NB_RDAGENT*NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
    output logic [NB_RDAGENT-1:0]                      rdaccept,
    output logic [NB_RDAGENT-1:0]                      rdvalid,
    input  logic [NB_RDAGENT-1:0]                      rdready,
    output logic [NB_RDAGENT*DATA_WIDTH-1:0]           rddata,
    output logic [NB_RDAGENT-1:0]                      rdcollision,
    output logic [NB_RDAGENT-1:0]                      rd_overflow
);

    localparam int IDXW = SELECT_WIDTH - WRITE_COLLISION;
    localparam int CW   = $clog2(FIFO_DEPTH + RAM_LATENCY + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);

    if (ADDR_WIDTH < 1) begin : g_bad_addr
        $error("ADDR_WIDTH must be at least 1");
    end
    if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_lat
        $error("RAM_LATENCY must be in 1..4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    for (genvar i = 0; i < NB_RDAGENT; i++) begin : g_agent
        logic [RAM_LATENCY-1:0]  pipe_vld;
        logic [SELECT_WIDTH-1:0] pipe_sel [RAM_LATENCY];
        logic [SELECT_WIDTH-1:0] last_sel;
        logic [IDXW-1:0]         idx;
        logic [DATA_WIDTH-1:0]   push_dat;
        logic                    push_col;
        logic [CW-1:0]           inflight;
        logic [CW-1:0]           occ;
        logic [PW-1:0]           wr_ptr;
        logic [PW-1:0]           rd_ptr;
        logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
        logic                    full;
        logic                    head_vld;
        logic                    push;
        logic                    pop;

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                pipe_vld <= '0;
                for (int k = 0; k < RAM_LATENCY; k++) pipe_sel[k] <= '0;
            end else begin
                pipe_vld[0] <= rden[i];
                pipe_sel[0] <= bank_select[i*SELECT_WIDTH +: SELECT_WIDTH];
                for (int k = 1; k < RAM_LATENCY; k++) begin
                    pipe_vld[k] <= pipe_vld[k-1];
                    pipe_sel[k] <= pipe_sel[k-1];
                end
            end
        end

        assign last_sel = pipe_sel[RAM_LATENCY-1];
        assign idx      = last_sel[IDXW-1:0];

        // Out-of-range bank indices read as zero rather than aliasing a real bank.
        always_comb begin
            push_dat = '0;
            for (int w = 0; w < NB_WRAGENT; w++) begin
                if (int'(idx) == w) begin
                    push_dat = bank_rddata[(i*NB_WRAGENT + w)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        if (WRITE_COLLISION != 0) begin : g_col
            assign push_col = last_sel[SELECT_WIDTH-1];
        end else begin : g_nocol
            assign push_col = 1'b0;
        end

        always_comb begin
            inflight = '0;
            for (int k = 0; k < RAM_LATENCY; k++) begin
                inflight = inflight + CW'(pipe_vld[k]);
            end
        end

        assign full     = (occ == CW'(FIFO_DEPTH));
        assign head_vld = (occ != '0);
        assign push     = pipe_vld[RAM_LATENCY-1] & ~full;
        assign pop      = head_vld & rdready[i];

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                occ    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= {push_col, push_dat};
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                occ <= occ + CW'(push) - CW'(pop);
            end
        end

        // Credits count queued words plus reads still travelling the align pipeline.
        assign rdaccept[i] = (occ + inflight) < CW'(FIFO_DEPTH);
        assign rdvalid[i]  = head_vld;
        assign rddata[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr][DATA_WIDTH-1:0];
        assign rdcollision[i] = mem[rd_ptr][DATA_WIDTH];

`ifdef MEDURAM_RD_OVERFLOW_CHECK_EN
        logic ovf;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                ovf <= 1'b0;
            end else if (rden[i] & ~rdaccept[i]) begin
                ovf <= 1'b1;
            end
        end
        assign rd_overflow[i] = ovf;
`else
        assign rd_overflow[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_meduram_read_collector.sv
// Bench for meduram_read_collector (RAM_LATENCY=2, FIFO_DEPTH=4): directed phases plus random traffic
// checked cycle by cycle against a queue-based model of outstanding reads and queued words.
module tb_meduram_read_collector;

    localparam int DW = 8;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int L  = 2;
    localparam int FD = 4;
    localparam int SW = 2;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NR-1:0]     rden;
    logic [NR*SW-1:0]  bank_select;
    logic [NR*NW*DW-1:0] bank_rddata;
    logic [NR-1:0]     rdaccept;
    logic [NR-1:0]     rdvalid;
    logic [NR-1:0]     rdready;
    logic [NR*DW-1:0]  rddata;
    logic [NR-1:0]     rdcollision;
    logic [NR-1:0]     rd_overflow;

    always #5 aclk = ~aclk;

    meduram_read_collector #(
        .ADDR_WIDTH(8), .DATA_WIDTH(DW), .NB_WRAGENT(NW), .NB_RDAGENT(NR),
        .WRITE_COLLISION(1), .RAM_LATENCY(L), .FIFO_DEPTH(FD)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .rden(rden), .bank_select(bank_select),
        .bank_rddata(bank_rddata), .rdaccept(rdaccept), .rdvalid(rdvalid),
        .rdready(rdready), .rddata(rddata), .rdcollision(rdcollision),
        .rd_overflow(rd_overflow)
    );

    // Model: words waiting in each FIFO, and reads issued but not yet landed (issue cycle + select).
    logic [8:0] fq [NR][$];
    int         it [NR][$];
    int         is [NR][$];
    logic       movf [NR];
    int         cyc;
    int         ntest;
    int         nfail;
    int         dut_pops [NR];
    int         cnt;
    int         acc_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_acc(input int i);
        return (fq[i].size() + it[i].size()) < FD;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            fq[i].delete();
            it[i].delete();
            is[i].delete();
            movf[i] = 1'b0;
        end
    endtask

    task automatic rnd_inputs();
        bank_rddata = $urandom;
        bank_select = 4'($urandom);
    endtask

    // Compare current outputs with the model, advance the model over one edge, then cross the edge.
    task automatic step();
        for (int i = 0; i < NR; i++) begin
            logic [8:0] head;
            logic [8:0] word;
            bit         acc_pre;
            bit         full;
            bit         popv;
            bit         pushv;
            int         sel;
            int         idx;
            acc_pre = m_acc(i);
            chk($sformatf("rdvalid[%0d]@%0d", i, cyc), 32'(rdvalid[i]), 32'(fq[i].size() != 0));
            chk($sformatf("rdaccept[%0d]@%0d", i, cyc), 32'(rdaccept[i]), 32'(acc_pre));
            chk($sformatf("rd_overflow[%0d]@%0d", i, cyc), 32'(rd_overflow[i]), 32'(movf[i]));
            if (fq[i].size() != 0) begin
                head = fq[i][0];
                chk($sformatf("rddata[%0d]@%0d", i, cyc), 32'(rddata[i*DW +: DW]), 32'(head[7:0]));
                chk($sformatf("rdcollision[%0d]@%0d", i, cyc), 32'(rdcollision[i]), 32'(head[8]));
            end
            if (rdvalid[i] && rdready[i]) dut_pops[i]++;

            full  = (fq[i].size() == FD);
            popv  = (fq[i].size() != 0) && rdready[i];
            pushv = 1'b0;
            word  = '0;
            if (it[i].size() != 0 && it[i][0] == cyc - L) begin
                sel = is[i][0];
                void'(it[i].pop_front());
                void'(is[i].pop_front());
                idx = sel % 2;
                word[8] = 1'((sel / 2) % 2);
                word[7:0] = (idx < NW) ? bank_rddata[(i*NW + idx)*DW +: DW] : 8'h00;
                pushv = 1'b1;
            end
            if (popv) void'(fq[i].pop_front());
            if (pushv && !full) fq[i].push_back(word);
`ifdef MEDURAM_RD_OVERFLOW_CHECK_EN
            if (rden[i] && !acc_pre) movf[i] = 1'b1;
`endif
            if (rden[i]) begin
                it[i].push_back(cyc);
                is[i].push_back(int'(bank_select[i*SW +: SW]));
            end
        end
        cyc++;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        ntest = 0;
        nfail = 0;
        cyc   = 0;
        model_clear();
        for (int i = 0; i < NR; i++) dut_pops[i] = 0;
        aresetn     = 1'b0;
        rden        = '0;
        rdready     = '0;
        bank_select = '0;
        bank_rddata = '0;
        #2;
        chk("reset_rdvalid", 32'(rdvalid), 32'h0);
        chk("reset_rdaccept", 32'(rdaccept), 32'h3);
        chk("reset_rddata", 32'(rddata), 32'h0);
        chk("reset_rdcollision", 32'(rdcollision), 32'h0);
        chk("reset_rd_overflow", 32'(rd_overflow), 32'h0);
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Basic read: agent 0, bank 1 returns 0xA5 two cycles later.
        rden = 2'b01; bank_select = 4'b0001; step();
        rden = 2'b00; step();
        bank_rddata = 32'h0000_A55A; step();
        chk("basic_vld", 32'(rdvalid[0]), 32'h1);
        chk("basic_dat", 32'(rddata[7:0]), 32'hA5);
        chk("basic_col", 32'(rdcollision[0]), 32'h0);
        rdready = 2'b01; step();
        rdready = 2'b00;
        chk("basic_pop", 32'(rdvalid[0]), 32'h0);

        // Collision select: bank 0 with the collision flag.
        rden = 2'b01; bank_select = 4'b0010; step();
        rden = 2'b00; step();
        bank_rddata = 32'h0000_113C; step();
        chk("col_dat", 32'(rddata[7:0]), 32'h3C);
        chk("col_flag", 32'(rdcollision[0]), 32'h1);
        rdready = 2'b01; step();
        rdready = 2'b00;

        // Backpressure on agent 1: only FIFO_DEPTH credits are handed out.
        cnt = 0;
        repeat (10) begin
            rnd_inputs();
            rden = {rdaccept[1], 1'b0};
            if (rdaccept[1]) cnt++;
            step();
        end
        rden = '0;
        chk("bp_accepted", 32'(cnt), 32'd4);
        chk("bp_accept_low", 32'(rdaccept[1]), 32'h0);
        rdready = 2'b10;
        dut_pops[1] = 0;
        repeat (8) begin
            rnd_inputs();
            step();
        end
        chk("bp_drained", 32'(dut_pops[1]), 32'd4);

        // Full-rate streaming on agent 0.
        rdready = 2'b01;
        dut_pops[0] = 0;
        acc_drop = 0;
        for (int n = 0; n < 16; n++) begin
            rnd_inputs();
            rden = 2'b01;
            if (!rdaccept[0]) acc_drop++;
            step();
        end
        rden = '0;
        repeat (L + 2) begin
            rnd_inputs();
            step();
        end
        chk("stream_cnt", 32'(dut_pops[0]), 32'd16);
        chk("stream_accept_drop", 32'(acc_drop), 32'd0);

        // Random traffic on both agents, issuing only when credits allow.
        repeat (400) begin
            rnd_inputs();
            for (int i = 0; i < NR; i++) rden[i] = m_acc(i) && ($urandom_range(0, 1) == 1);
            rdready = 2'($urandom);
            step();
        end
        rden = '0;
        rdready = 2'b11;
        repeat (8) begin
            rnd_inputs();
            step();
        end

        // Overflow: fill agent 0, then force reads against a closed credit window.
        rdready = '0;
        repeat (8) begin
            rnd_inputs();
            rden = {1'b0, m_acc(0)};
            step();
        end
        rden = 2'b01;
        repeat (3) begin
            rnd_inputs();
            step();
        end
        rden = '0;
        repeat (4) begin
            rnd_inputs();
            step();
        end
`ifdef MEDURAM_RD_OVERFLOW_CHECK_EN
        chk("ovf_flag", 32'(rd_overflow[0]), 32'h1);
`else
        chk("ovf_flag", 32'(rd_overflow[0]), 32'h0);
`endif
        rdready = 2'b01;
        dut_pops[0] = 0;
        repeat (8) begin
            rnd_inputs();
            step();
        end
        rdready = '0;
        chk("ovf_drop", 32'(dut_pops[0]), 32'd4);

        // Reset mid-stream: 2 words queued on agent 1 and one read in flight.
        rden = 2'b10; rnd_inputs(); step();
        rden = 2'b10; rnd_inputs(); step();
        rden = 2'b00; rnd_inputs(); step();
        rnd_inputs(); step();
        rden = 2'b10; rnd_inputs(); step();
        rden = 2'b00;
        chk("rst_pre_vld", 32'(rdvalid[1]), 32'h1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_rdvalid", 32'(rdvalid), 32'h0);
        chk("rst_mid_rdaccept", 32'(rdaccept), 32'h3);
        chk("rst_mid_overflow", 32'(rd_overflow), 32'h0);
        model_clear();
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        repeat (6) begin
            rnd_inputs();
            step();
        end
        chk("rst_no_stale", 32'(rdvalid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
